// File: rtl/box_plot_arbiter_pkg.sv
// Shared types and screen constants for the box-paint arbiter and its pixel scanner.
package box_plot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int REQ_ERASE  = 0;
  localparam int REQ_PLAYER = 1;
  localparam int REQ_GOAL   = 2;

  localparam int CELL     = 10;
  localparam int X_OFF    = 80;
  localparam int MAX_CELL = 23;

  localparam logic [2:0] BLACK = 3'b000;

  function automatic logic [2:0] req_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/box_pixel_scanner.sv
// Raster walk over one BOX x BOX square, one registered pixel address per clock.
module box_pixel_scanner #(
  parameter int CELL  = box_plot_arbiter_pkg::CELL,
  parameter int BOX   = 9,
  parameter int X_OFF = box_plot_arbiter_pkg::X_OFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] cell_x,
  input  logic [4:0] cell_y,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       plot,
  output logic       last
);

  localparam int CW = (BOX > 1) ? $clog2(BOX) : 1;

  logic [CW-1:0] cx_cnt_reg, cy_cnt_reg;
  logic [CW-1:0] cx_cnt_next, cy_cnt_next;
  logic [8:0]    base_x_reg, x_reg, start_x;
  logic [7:0]    base_y_reg, y_reg, start_y;
  logic          plot_reg;

  // Constant-coefficient products; the square origin is captured once at start.
  assign start_x = 9'(X_OFF) + 9'(cell_x) * 9'(CELL);
  assign start_y = 8'(cell_y) * 8'(CELL);

  assign last = plot_reg && (cx_cnt_reg == CW'(BOX - 1)) && (cy_cnt_reg == CW'(BOX - 1));
  assign x    = x_reg;
  assign y    = y_reg;
  assign plot = plot_reg;

  always_comb begin
    cx_cnt_next = cx_cnt_reg + CW'(1);
    cy_cnt_next = cy_cnt_reg;
    if (cx_cnt_reg == CW'(BOX - 1)) begin
      cx_cnt_next = '0;
      cy_cnt_next = cy_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_cnt_reg <= '0;
      cy_cnt_reg <= '0;
      base_x_reg <= '0;
      base_y_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      plot_reg   <= 1'b0;
    end else if (start) begin
      base_x_reg <= start_x;
      base_y_reg <= start_y;
      x_reg      <= start_x;
      y_reg      <= start_y;
      cx_cnt_reg <= '0;
      cy_cnt_reg <= '0;
      plot_reg   <= 1'b1;
    end else if (plot_reg) begin
      if (last) begin
        plot_reg   <= 1'b0;
        x_reg      <= '0;
        y_reg      <= '0;
        cx_cnt_reg <= '0;
        cy_cnt_reg <= '0;
      end else begin
        cx_cnt_reg <= cx_cnt_next;
        cy_cnt_reg <= cy_cnt_next;
        x_reg      <= base_x_reg + 9'(cx_cnt_next);
        y_reg      <= base_y_reg + 8'(cy_cnt_next);
      end
    end
  end

endmodule

// File: rtl/box_plot_arbiter.sv
// Fixed-priority arbiter sharing the VGA plot port between erase, player and goal box painters.
module box_plot_arbiter #(
  parameter int CELL     = box_plot_arbiter_pkg::CELL,
  parameter int BOX      = 9,
  parameter int X_OFF    = box_plot_arbiter_pkg::X_OFF,
  parameter int MAX_CELL = box_plot_arbiter_pkg::MAX_CELL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [14:0] req_cx,
  input  logic [14:0] req_cy,
  input  logic [8:0]  req_colour,
  output logic [2:0]  ack,
  output logic        err,
  output logic        busy,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  import box_plot_arbiter_pkg::*;

  state_t     state_reg;
  logic [2:0] grant_reg, ack_reg, colour_reg;
  logic       err_reg, busy_reg;

  logic [4:0] cell_x_in [3];
  logic [4:0] cell_y_in [3];
  logic [2:0] colour_in [3];
  logic [1:0] sel_idx;
  logic [4:0] sel_cx, sel_cy;
  logic [2:0] sel_colour;
  logic       range_bad, scan_start, scan_last;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign cell_x_in[gi] = req_cx[5*gi +: 5];
      assign cell_y_in[gi] = req_cy[5*gi +: 5];
      assign colour_in[gi] = req_colour[3*gi +: 3];
    end
  endgenerate

  // Erase wins so a moved player box is never painted over by its own erase.
  always_comb begin
    sel_idx = 2'(REQ_ERASE);
    if (req[REQ_ERASE])       sel_idx = 2'(REQ_ERASE);
    else if (req[REQ_PLAYER]) sel_idx = 2'(REQ_PLAYER);
    else if (req[REQ_GOAL])   sel_idx = 2'(REQ_GOAL);
  end

  assign sel_cx     = cell_x_in[sel_idx];
  assign sel_cy     = cell_y_in[sel_idx];
  assign sel_colour = colour_in[sel_idx];
  assign range_bad  = (sel_cx > 5'(MAX_CELL)) || (sel_cy > 5'(MAX_CELL));
  assign scan_start = (state_reg == IDLE) && (req != 3'b000) && !range_bad;

  box_pixel_scanner #(
    .CELL  (CELL),
    .BOX   (BOX),
    .X_OFF (X_OFF)
  ) u_scanner (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .cell_x (sel_cx),
    .cell_y (sel_cy),
    .x      (x),
    .y      (y),
    .plot   (plot),
    .last   (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      ack_reg    <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      colour_reg <= BLACK;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= '0;
          err_reg <= 1'b0;
          if (req != 3'b000) begin
            grant_reg <= req_onehot(sel_idx);
            busy_reg  <= 1'b1;
            if (range_bad) begin
              // Bad coordinate: skip painting and report on the ack cycle.
              state_reg  <= DONE;
              ack_reg    <= req_onehot(sel_idx);
              err_reg    <= 1'b1;
              colour_reg <= BLACK;
            end else begin
              state_reg  <= SCAN;
              colour_reg <= sel_colour;
            end
          end
        end
        SCAN: begin
          if (scan_last) begin
            state_reg  <= DONE;
            ack_reg    <= grant_reg;
            colour_reg <= BLACK;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          ack_reg   <= '0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          grant_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack    = ack_reg;
  assign err    = err_reg;
  assign busy   = busy_reg;
  assign colour = colour_reg;

endmodule

// File: tb/tb_box_plot_arbiter.sv
// Directed bench: expected pixels and acks are queued at request time and popped as the DUT emits them.
module tb_box_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [14:0] req_cx = '0;
  logic [14:0] req_cy = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  ack;
  logic        err, busy, plot;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;

  box_plot_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_cx     (req_cx),
    .req_cy     (req_cy),
    .req_colour (req_colour),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {int a; int e;} ack_t;

  pix_t pix_q[$];
  ack_t ack_q[$];
  int   rise_q[$];
  int   ackedge_q[$];

  int   checks = 0, errors = 0;
  int   edge_cnt = 0, plot_cnt = 0, busy_low = 0, s_edge = 0, n = 0;
  logic prev_plot = 1'b0;
  logic track_busy = 1'b0;
  logic [2:0] hold_mask = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_box(input int cx, input int cy, input int col);
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        pix_t p;
        p.x = 80 + cx * 10 + c;
        p.y = cy * 10 + r;
        p.c = col;
        pix_q.push_back(p);
      end
    end
  endtask

  task automatic push_ack(input int a, input int e);
    ack_t k;
    k.a = a;
    k.e = e;
    ack_q.push_back(k);
  endtask

  task automatic set_req(input int idx, input int cx, input int cy, input int col);
    req_cx[idx*5 +: 5]     = 5'(cx);
    req_cy[idx*5 +: 5]     = 5'(cy);
    req_colour[idx*3 +: 3] = 3'(col);
  endtask

  task automatic begin_test();
    plot_cnt = 0;
    rise_q.delete();
    ackedge_q.delete();
  endtask

  // One clock: sample outputs 1 time unit after the edge and score them.
  task automatic step();
    pix_t p;
    ack_t k;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (plot === 1'b1) begin
      plot_cnt++;
      if (prev_plot !== 1'b1) rise_q.push_back(edge_cnt);
      if (pix_q.size() == 0) begin
        check("plot_unexpected", {31'b0, plot}, 0);
      end else begin
        p = pix_q.pop_front();
        check("x", x, p.x);
        check("y", y, p.y);
        check("colour", colour, p.c);
      end
    end
    prev_plot = plot;
    if (ack !== 3'b000) begin
      ackedge_q.push_back(edge_cnt);
      $display("edge %0d: ack %b err %b", edge_cnt, ack, err);
      if (ack_q.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        k = ack_q.pop_front();
        check("ack", ack, k.a);
        check("err", err, k.e);
      end
      req       = req & ~(ack & ~hold_mask);
      hold_mask = hold_mask & ~ack;
    end else if (err !== 1'b0) begin
      check("err_without_ack", err, 0);
    end
    if (track_busy && busy !== 1'b1) busy_low++;
  endtask

  task automatic wait_done(input int budget);
    int cnt;
    cnt = 0;
    while ((pix_q.size() != 0 || ack_q.size() != 0) && cnt < budget) begin
      step();
      cnt++;
    end
    check("pixels_left", pix_q.size(), 0);
    check("acks_left", ack_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_plot", plot, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Single erase: (100,30)..(108,38), ack at spec cycle E0+82 (observed after edge E0+81)
    begin_test();
    set_req(0, 2, 3, 0);
    req = 3'b001;
    push_box(2, 3, 0);
    push_ack(1, 0);
    s_edge = edge_cnt + 1;
    wait_done(200);
    check("t1_plot_count", plot_cnt, 81);
    check("t1_first_pixel_edge", rise_q[0] - s_edge, 0);
    check("t1_ack_edge", ackedge_q[0] - s_edge, 81);
    repeat (3) step();

    // Simultaneous erase + player
    begin_test();
    set_req(0, 2, 3, 0);
    set_req(1, 3, 3, 2);
    req = 3'b011;
    push_box(2, 3, 0);
    push_box(3, 3, 2);
    push_ack(1, 0);
    push_ack(2, 0);
    wait_done(400);
    check("t2_plot_count", plot_cnt, 162);
    check("t2_player_start_gap", rise_q[1] - ackedge_q[0], 2);
    repeat (3) step();

    // Late goal arrival mid-scan; player inputs change but must stay frozen
    begin_test();
    set_req(1, 5, 7, 6);
    req = 3'b010;
    push_box(5, 7, 6);
    push_ack(2, 0);
    repeat (40) step();
    set_req(2, 0, 0, 7);
    set_req(1, 9, 9, 1);
    req = req | 3'b100;
    push_box(0, 0, 7);
    push_ack(4, 0);
    wait_done(400);
    check("t3_plot_count", plot_cnt, 162);
    repeat (3) step();

    // Out of range on x (goal) and on y (erase)
    begin_test();
    set_req(2, 24, 0, 5);
    req = 3'b100;
    push_ack(4, 1);
    s_edge = edge_cnt + 1;
    wait_done(20);
    check("t4_ack_edge", ackedge_q[0] - s_edge, 0);
    repeat (3) step();
    set_req(0, 0, 31, 3);
    req = 3'b001;
    push_ack(1, 1);
    wait_done(20);
    repeat (3) step();
    check("t4_plot_count", plot_cnt, 0);

    // Largest legal cell: last pixel (318,238)
    begin_test();
    set_req(2, 23, 23, 5);
    req = 3'b100;
    push_box(23, 23, 5);
    push_ack(4, 0);
    wait_done(200);
    check("t5_plot_count", plot_cnt, 81);
    repeat (3) step();

    // Reset at pixel 40 clears outputs asynchronously; re-request restarts at (120,10)
    begin_test();
    set_req(1, 4, 1, 3);
    req = 3'b010;
    push_box(4, 1, 3);
    push_ack(2, 0);
    n = 0;
    while (plot_cnt < 40 && n < 100) begin
      step();
      n++;
    end
    check("t6_reached_pixel", plot_cnt, 40);
    reset = 1'b1;
    #1;
    check("t6_async_plot", plot, 0);
    check("t6_async_x", x, 0);
    check("t6_async_y", y, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ack", ack, 0);
    pix_q.delete();
    ack_q.delete();
    req = 3'b000;
    step();
    step();
    reset = 1'b0;
    step();
    begin_test();
    req = 3'b010;
    push_box(4, 1, 3);
    push_ack(2, 0);
    wait_done(200);
    check("t6_plot_count", plot_cnt, 81);
    repeat (3) step();

    // Player req held through its ack: served twice, busy low for one IDLE cycle
    begin_test();
    set_req(1, 1, 1, 1);
    hold_mask = 3'b010;
    req = 3'b010;
    push_box(1, 1, 1);
    push_box(1, 1, 1);
    push_ack(2, 0);
    push_ack(2, 0);
    step();
    busy_low = 0;
    track_busy = 1'b1;
    wait_done(400);
    track_busy = 1'b0;
    check("t7_busy_low_cycles", busy_low, 1);
    check("t7_plot_count", plot_cnt, 162);
    check("t7_restart_gap", rise_q[1] - ackedge_q[0], 2);
    repeat (3) step();
    check("t7_req_dropped", req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_plot_arbiter.md
Name: box_plot_arbiter

Overview:
- Shares the single VGA plot port between three box-paint requesters: erase old player box, draw new player box, draw goal/marker tile.
- Grants one requester at a time by fixed priority and latches its maze-cell coordinate and colour.
- Scans a BOX x BOX pixel square at screen offset X_OFF with one pixel per clock, then acknowledges the requester.
- Sits between the game FSM and the VGA adapter and replaces per-requester pixel counters.

Parameters:
- CELL, 10, pixel pitch of one maze cell.
- BOX, 9, side of painted square in pixels; must satisfy BOX <= CELL.
- X_OFF, 80, horizontal screen offset of maze origin.
- MAX_CELL, 23, largest legal cell index on either axis.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  3  per-requester level request; bit0 erase, bit1 player, bit2 goal
- req_cx  in  15  packed cell x, 5 bits per requester, requester i at [5i+4:5i]
- req_cy  in  15  packed cell y, same packing
- req_colour  in  9  packed colour, 3 bits per requester
- ack  out  3  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse, coincident with ack, when the granted coordinate is out of range
- busy  out  1  high in SCAN and DONE
- x  out  9  VGA x
- y  out  8  VGA y
- colour  out  3  VGA colour
- plot  out  1  VGA write enable

Behaviour:
- Reset (async, active-high): state IDLE; ack, err, busy, plot, x, y, colour = 0; counters cx, cy = 0; grant register cleared. An in-flight request is dropped with no ack. The requester must re-request.
- States: IDLE, SCAN, DONE.
- IDLE, req == 0: stay in IDLE; all outputs 0.
- IDLE, req != 0: at the clock edge, grant the lowest set bit (0 > 1 > 2) and latch its cx, cy and colour. Set cx_cnt = cy_cnt = 0.
  - If latched cx > MAX_CELL or cy > MAX_CELL: go to DONE and set the err flag.
  - Otherwise go to SCAN.
- The latched coordinate and colour are frozen for the whole operation; later input changes have no effect.
- SCAN, each cycle:
  - plot = 1.
  - x = X_OFF + cx*CELL + cx_cnt, computed at 9 bits.
  - y = cy*CELL + cy_cnt, computed at 8 bits.
  - colour = latched colour.
  - Pixel order is raster: cx_cnt counts 0..BOX-1; at BOX-1 it wraps to 0 and cy_cnt increments.
  - The pixel with cx_cnt = cy_cnt = BOX-1 is the last; the next state is DONE.
  - Exactly BOX*BOX plot cycles occur.
- Arithmetic: multiply by CELL as a constant product. With defaults, max x = 80+230+8 = 318 and max y = 238; no overflow is possible.
- DONE (one cycle):
  - plot = 0, x = y = 0.
  - ack[granted] = 1, all other ack bits 0.
  - err = 1 only if the out-of-range path was taken.
  - Next state IDLE.
- Outputs are registered: plot, x, y and colour change on clock edges only.
- Latency: request sampled at edge E0; first pixel in cycle E0+1; last pixel at E0+BOX*BOX; ack at E0+BOX*BOX+1. With defaults, ack is 82 cycles after sampling.
- Minimum request-to-request spacing is therefore BOX*BOX+2 cycles.
- Requests raised during SCAN or DONE are held pending, not lost, since req is level-sensitive. They are arbitrated in the first IDLE cycle after DONE.
- A requester must drop req in the cycle ack is seen. A req still high in the IDLE cycle after its own ack is a new request and is served again.
- Simultaneous requests: served one per IDLE visit in priority order. An erase raised together with a player draw is always painted first, so the new box is never overwritten.
- Starvation of bit2 under continuous bit0/bit1 traffic is accepted by design.

Decomposition:
- Shared package:
  - state encoding (IDLE, SCAN, DONE);
  - requester index constants REQ_ERASE = 0, REQ_PLAYER = 1, REQ_GOAL = 2;
  - screen constants CELL, X_OFF, MAX_CELL;
  - colour constant BLACK = 3'b000.
- One natural sub-module: box_pixel_scanner. It holds the cx_cnt/cy_cnt raster counter and the address adder. Inputs are start and the latched cell; outputs are x, y, plot and last.
- The arbiter/FSM remains in box_plot_arbiter.

Test Plan:
- Single erase: req = 3'b001, cx = 2, cy = 3, colour 0 -> 81 plot cycles; first pixel (100,30); last pixel (108,38); ack = 3'b001 exactly one cycle, 82 cycles after sampling; err = 0.
- Simultaneous: req = 3'b011, erase at (2,3), player at (3,3) colour 3'b010 -> erase completes first; player scan starts two cycles after the erase ack; first player pixel (110,30) colour 010; ack bits pulse in order 001 then 010.
- Late arrival: goal req raised mid-scan of player -> no effect on current pixels; served after the player's DONE; no pixel is dropped or duplicated (count 81 + 81).
- Out of range: req = 3'b100, cx = 24 -> no plot cycles; ack = 3'b100 and err = 1 in the cycle after sampling.
- Reset mid-scan: assert reset at pixel 40 -> plot, x, y and busy go 0 immediately (asynchronously); no ack; re-request after release restarts at pixel (X_OFF+cx*10, cy*10).
- Held request: req bit1 kept high through its ack -> a second full 81-pixel scan begins; busy stays high except the single IDLE cycle.
